// File: rtl/err_loc_receiver_if.sv
// Error-location receiver bus: serial location strobe in, packed result out.
// The decoder/downstream side uses master; the receiver uses slave.
interface err_loc_receiver_if;
    logic       i_valid;
    logic [9:0] i_err_loc;
    logic       i_res_ready;
    logic       o_res_valid;
    logic [2:0] o_num_err;
    logic [9:0] o_loc0;
    logic [9:0] o_loc1;
    logic [9:0] o_loc2;
    logic [9:0] o_loc3;
    logic [9:0] o_loc4;
    logic [9:0] o_loc5;
    logic       o_overflow;
    logic       o_busy;

    modport master (
        output i_valid, i_err_loc, i_res_ready,
        input  o_res_valid, o_num_err, o_loc0, o_loc1, o_loc2, o_loc3, o_loc4, o_loc5,
        input  o_overflow, o_busy
    );

    modport slave (
        input  i_valid, i_err_loc, i_res_ready,
        output o_res_valid, o_num_err, o_loc0, o_loc1, o_loc2, o_loc3, o_loc4, o_loc5,
        output o_overflow, o_busy
    );
endinterface

// File: rtl/err_loc_receiver.sv
// Collects up to six error locations per frame into a held result register.
// Define ERR_LOC_RECEIVER_SORT_EN to keep stored locations in ascending order.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no frame open; next i_valid opens one
// S_COLLECT | frame open; entries accepted until i_valid drops or 6 stored
module err_loc_receiver (
    input  logic              i_clk,
    input  logic              i_rst_n,
    err_loc_receiver_if.slave bus
);
    typedef enum logic {S_IDLE, S_COLLECT} state_t;
    localparam logic [9:0] NO_ERR = 10'd1023;

    state_t     state_q, state_d;
    logic [2:0] col_cnt_q;
    logic [9:0] col_loc_q [6];
    logic [2:0] base_cnt;
    logic [9:0] base_loc  [6];
    logic [2:0] upd_cnt;
    logic [9:0] upd_loc   [6];
    logic       frame_open;
    logic       do_store;
    logic       frame_close;
    logic       out_load;
    logic       out_valid_q;
    logic       overflow_q;
    logic [2:0] out_cnt_q;
    logic [9:0] out_loc_q [6];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            col_cnt_q <= 3'd0;
            for (int i = 0; i < 6; i++) col_loc_q[i] <= NO_ERR;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= upd_cnt;
            for (int i = 0; i < 6; i++) col_loc_q[i] <= upd_loc[i];
        end
    end

    always_comb begin
        frame_open = (state_q == S_IDLE) && bus.i_valid;
        base_cnt   = col_cnt_q;
        for (int i = 0; i < 6; i++) base_loc[i] = col_loc_q[i];
        if (frame_open) begin
            base_cnt = 3'd0;
            for (int i = 0; i < 6; i++) base_loc[i] = NO_ERR;
        end

        do_store = bus.i_valid && (bus.i_err_loc != NO_ERR) && (base_cnt < 3'd6);
        upd_cnt  = base_cnt;
        for (int i = 0; i < 6; i++) upd_loc[i] = base_loc[i];
        if (do_store) begin
            upd_cnt = base_cnt + 3'd1;
`ifdef ERR_LOC_RECEIVER_SORT_EN
            // Empty slots hold 1023, which exceeds any storable value, so they shift like real entries.
            if (base_loc[0] > bus.i_err_loc) upd_loc[0] = bus.i_err_loc;
            for (int i = 1; i < 6; i++) begin
                if (base_loc[i] > bus.i_err_loc) begin
                    upd_loc[i] = (base_loc[i-1] <= bus.i_err_loc) ? bus.i_err_loc : base_loc[i-1];
                end
            end
`else
            for (int i = 0; i < 6; i++) begin
                if (base_cnt == 3'(i)) upd_loc[i] = bus.i_err_loc;
            end
`endif
        end

        // When i_valid is low in COLLECT, upd_* equals the collecting registers.
        frame_close = ((state_q == S_COLLECT) && !bus.i_valid) || (do_store && (upd_cnt == 3'd6));

        state_d = state_q;
        if (frame_close)      state_d = S_IDLE;
        else if (bus.i_valid) state_d = S_COLLECT;

        out_load = frame_close && (!out_valid_q || bus.i_res_ready);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_cnt_q   <= 3'd0;
            for (int i = 0; i < 6; i++) out_loc_q[i] <= NO_ERR;
        end else begin
            if (out_load) begin
                out_valid_q <= 1'b1;
                out_cnt_q   <= upd_cnt;
                for (int i = 0; i < 6; i++) out_loc_q[i] <= upd_loc[i];
            end else if (out_valid_q && bus.i_res_ready) begin
                out_valid_q <= 1'b0;
            end
            if (frame_close && out_valid_q && !bus.i_res_ready) overflow_q <= 1'b1;
        end
    end

    assign bus.o_res_valid = out_valid_q;
    assign bus.o_num_err   = out_cnt_q;
    assign bus.o_loc0      = out_loc_q[0];
    assign bus.o_loc1      = out_loc_q[1];
    assign bus.o_loc2      = out_loc_q[2];
    assign bus.o_loc3      = out_loc_q[3];
    assign bus.o_loc4      = out_loc_q[4];
    assign bus.o_loc5      = out_loc_q[5];
    assign bus.o_overflow  = overflow_q;
    assign bus.o_busy      = (state_q == S_COLLECT);
endmodule

// File: doc/err_loc_receiver.md
ERR_LOC_RECEIVER -- requirements
Module: err_loc_receiver

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low: i_clk  in  1  rising-edge clock; i_rst_n  in  1  async active-low reset.
REQ-002 SHALL have i_valid  in  1  serial error-location strobe from the decoder output stage.
REQ-003 SHALL have i_err_loc  in  10  error location; 10'd1023 = "no error" marker.
REQ-004 SHALL have i_res_ready  in  1  downstream accepts the result.
REQ-005 SHALL have o_res_valid  out  1  packed result held for downstream.
REQ-006 SHALL have o_num_err  out  3  count of stored locations, 0..6.
REQ-007 SHALL have o_loc0..o_loc5  out  10 each  stored locations; unused slots = 10'd1023.
REQ-008 SHALL have o_overflow  out  1  sticky flag: a completed frame was dropped.
REQ-009 SHALL have o_busy  out  1  high while in COLLECT.

Function
REQ-010 SHALL use a two-state FSM, IDLE and COLLECT, plus a separate output holding register with its own valid bit.
REQ-011 IDLE -> COLLECT SHALL occur on a cycle with i_valid=1; that cycle's location is the frame's first entry.
REQ-012 In COLLECT, each i_valid=1 cycle SHALL add one entry.
REQ-013 In COLLECT, the first i_valid=0 cycle SHALL close the frame and return the FSM to IDLE.
REQ-014 The frame SHALL also close in the cycle its 6th stored entry arrives; the next i_valid=1 cycle then starts a new frame.
REQ-015 An entry equal to 1023 SHALL NOT be stored and SHALL NOT increment the count, but SHALL still open or extend a frame.
REQ-016 Stored entries SHALL fill slots 0..5 in arrival order, and the count SHALL saturate at 6.
REQ-017 Frame close SHALL transfer the collecting registers to the output register at the closing clock edge, so o_res_valid is high the next cycle; latency from the last entry is 1 cycle (6th-entry close) or 2 cycles (idle close).
REQ-018 o_res_valid SHALL hold its value and data until a cycle with o_res_valid and i_res_ready both 1; it SHALL clear on that edge unless a new frame closes on the same edge, in which case the new result loads and o_res_valid stays 1.
REQ-019 If a frame closes while o_res_valid=1 and i_res_ready=0, the new frame SHALL be discarded, the held result SHALL stay unchanged, and o_overflow SHALL set.
REQ-020 The collecting registers SHALL reinitialise to count 0 and all slots 1023 at every frame open.
REQ-021 A frame of only 1023 markers SHALL complete with o_num_err=0 and all slots 1023.

Reset
REQ-022 While i_rst_n=0, the FSM SHALL be IDLE, o_res_valid=0, o_num_err=0, o_loc0..5=1023, o_overflow=0 and o_busy=0.
REQ-023 Assertion of reset mid-frame SHALL immediately discard the partial frame and any held result; no result is emitted for it.
REQ-024 The only way to clear o_overflow SHALL be reset.

Configuration
REQ-025 SHALL provide macro ERR_LOC_RECEIVER_SORT_EN to compile sorting in or out.
REQ-026 With ERR_LOC_RECEIVER_SORT_EN defined, each stored entry SHALL be insertion-sorted in the same cycle, so slots 0..count-1 are ascending and duplicates are kept adjacent.
REQ-027 Without ERR_LOC_RECEIVER_SORT_EN, slots SHALL hold arrival order.
REQ-028 Timing and all other behaviour SHALL be identical with and without the macro.

Verification
REQ-029 Bench SHALL cover: i_valid high 3 cycles with locs 500,12,300, then low -> o_res_valid 2 cycles after the last entry; num_err=3; slots 500,12,300,1023,1023,1023 without sort, or 12,300,500,1023,1023,1023 with sort.
REQ-030 Bench SHALL cover: single valid with 1023 -> num_err=0, all slots 1023, o_res_valid=1.
REQ-031 Bench SHALL cover: 7 consecutive valids with locs 1..7 -> first frame num_err=6 (1..6) valid 1 cycle after loc 6; loc 7 opens a second frame with num_err=1.
REQ-032 Bench SHALL cover: i_res_ready=0; two frames with locs 5 then 9 -> held result stays loc0=5; o_overflow=1 after the second close; it stays 1 after ready=1.
REQ-033 Bench SHALL cover: result held, i_res_ready=1 on the same edge a new frame closes -> o_res_valid stays 1 and data switches to the new frame.
REQ-034 Bench SHALL cover: reset pulse after the 2nd of 4 valids -> no result, all outputs at reset values, next frame collects normally.
